div_result_bcd: RTL and testbench

//  Downstream stage of the signed divider. Captures Quotient/Remainder on each fresh rising

---
 rtl/div_result_bcd_pkg.sv | 14 +
 rtl/div_result_bcd_if.sv | 28 ++
 rtl/div_result_bcd_dabble_step.sv | 26 ++
 rtl/div_result_bcd.sv | 165 ++++++++++++++++
 tb/tb_div_result_bcd.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/div_result_bcd_pkg.sv
// Shared constants for the divider result BCD converter: FSM encodings and
// double-dabble digit constants.
package div_result_bcd_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV_Q = 2'd1;
    localparam logic [1:0] ST_CONV_R = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int BCD_DIGIT_W   = 4;
    localparam int DABBLE_ADD    = 3;
    localparam int DABBLE_THRESH = 5;

endpackage

// File: rtl/div_result_bcd_if.sv
// Bundle between the signed divider / display consumer (master) and the
// BCD result stage (slave). Suffixes are from the slave's point of view.
interface div_result_bcd_if #(
    parameter int W      = 8,
    parameter int DIGITS = 3
);
    logic                  in_ready_i;
    logic [W-1:0]          quotient_i;
    logic [W-1:0]          remainder_i;
    logic                  sign_i;
    logic                  ack_i;
    logic                  busy_o;
    logic                  valid_o;
    logic                  quot_neg_o;
    logic                  rem_neg_o;
    logic [4*DIGITS-1:0]   quot_bcd_o;
    logic [4*DIGITS-1:0]   rem_bcd_o;

    modport master (
        output in_ready_i, quotient_i, remainder_i, sign_i, ack_i,
        input  busy_o, valid_o, quot_neg_o, rem_neg_o, quot_bcd_o, rem_bcd_o
    );

    modport slave (
        input  in_ready_i, quotient_i, remainder_i, sign_i, ack_i,
        output busy_o, valid_o, quot_neg_o, rem_neg_o, quot_bcd_o, rem_bcd_o
    );
endinterface

// File: rtl/div_result_bcd_dabble_step.sv
// One combinational double-dabble step over the {BCD digits, binary} column:
// every digit >= 5 gets +3, then the whole column shifts left by one.
module bcd_dabble_step
    import div_result_bcd_pkg::*;
#(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic [DIGITS*BCD_DIGIT_W+W-1:0] col_i,
    output logic [DIGITS*BCD_DIGIT_W+W-1:0] col_o
);
    logic [DIGITS*BCD_DIGIT_W+W-1:0] adj;

    // Digit correction followed by the shift; the MSB shifted out is always 0
    // as long as DIGITS is large enough for the input range.
    always_comb begin
        adj = col_i;
        for (int d = 0; d < DIGITS; d++) begin
            if (adj[W + d*BCD_DIGIT_W +: BCD_DIGIT_W] >= BCD_DIGIT_W'(DABBLE_THRESH)) begin
                adj[W + d*BCD_DIGIT_W +: BCD_DIGIT_W] =
                    adj[W + d*BCD_DIGIT_W +: BCD_DIGIT_W] + BCD_DIGIT_W'(DABBLE_ADD);
            end
        end
        col_o = adj << 1;
    end
endmodule

// File: rtl/div_result_bcd.sv
// Divider result stage: captures quotient/remainder on a fresh Ready edge,
// converts each to sign + BCD magnitude with one shared double-dabble step,
// and holds the result under a Valid/Ack handshake.
//   state   | meaning
//   IDLE    | waiting for a rising edge of in_ready
//   CONV_Q  | W dabble steps on the quotient magnitude
//   CONV_R  | W dabble steps on the remainder magnitude
//   DONE    | result presented, waiting for ack
module div_result_bcd
    import div_result_bcd_pkg::*;
#(
    parameter int INPUT_BIT_WIDTH = 8,
    parameter int DIGITS          = 3
) (
    input logic             clk,
    input logic             rst_n,
    div_result_bcd_if.slave bus
);
    localparam int W  = INPUT_BIT_WIDTH;
    localparam int BW = DIGITS * BCD_DIGIT_W;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q;
    logic [BW-1:0] bcd_q, bcd_d;
    logic [W-1:0]  bin_q, bin_d;
    logic [W-1:0]  rem_mag_q, rem_mag_d;
    logic [BW-1:0] qpark_q, qpark_d;
    logic          qneg_cap_q, qneg_cap_d;
    logic          rneg_cap_q, rneg_cap_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic          quot_neg_q, quot_neg_d;
    logic          rem_neg_q, rem_neg_d;
    logic [BW-1:0] quot_bcd_q, quot_bcd_d;
    logic [BW-1:0] rem_bcd_q, rem_bcd_d;

    logic          start;
    logic          q_neg, r_neg;
    logic [W-1:0]  q_mag, r_mag;
    logic [BW+W-1:0] step_col;

    assign start = bus.in_ready_i & ~ready_q;

    // Negation happens once at capture; -2^(W-1) maps to 2^(W-1) unsigned.
    assign q_neg = bus.sign_i & bus.quotient_i[W-1];
    assign r_neg = bus.sign_i & bus.remainder_i[W-1];
    assign q_mag = q_neg ? -bus.quotient_i  : bus.quotient_i;
    assign r_mag = r_neg ? -bus.remainder_i : bus.remainder_i;

    bcd_dabble_step #(.W(W), .DIGITS(DIGITS)) u_step (
        .col_i (({bcd_q, bin_q})),
        .col_o (step_col)
    );

    // Next-state logic for the sequencer, shift column and output registers.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        bin_d      = bin_q;
        rem_mag_d  = rem_mag_q;
        qpark_d    = qpark_q;
        qneg_cap_d = qneg_cap_q;
        rneg_cap_d = rneg_cap_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        quot_bcd_d = quot_bcd_q;
        rem_bcd_d  = rem_bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_d      = q_mag;
                    rem_mag_d  = r_mag;
                    qneg_cap_d = q_neg;
                    rneg_cap_d = r_neg;
                    bcd_d      = '0;
                    cnt_d      = CNT_LAST;
                    busy_d     = 1'b1;
                    state_d    = ST_CONV_Q;
                end
            end
            ST_CONV_Q: begin
                {bcd_d, bin_d} = step_col;
                cnt_d          = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    qpark_d = step_col[W +: BW];
                    bcd_d   = '0;
                    bin_d   = rem_mag_q;
                    cnt_d   = CNT_LAST;
                    state_d = ST_CONV_R;
                end
            end
            ST_CONV_R: begin
                {bcd_d, bin_d} = step_col;
                cnt_d          = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    quot_bcd_d = qpark_q;
                    rem_bcd_d  = step_col[W +: BW];
                    quot_neg_d = qneg_cap_q;
                    rem_neg_d  = rneg_cap_q;
                    busy_d     = 1'b0;
                    valid_d    = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.ack_i) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; Ready history resets high so a level already present
    // at reset release does not count as a new result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            bcd_q      <= '0;
            bin_q      <= '0;
            rem_mag_q  <= '0;
            qpark_q    <= '0;
            qneg_cap_q <= 1'b0;
            rneg_cap_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            quot_bcd_q <= '0;
            rem_bcd_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= bus.in_ready_i;
            bcd_q      <= bcd_d;
            bin_q      <= bin_d;
            rem_mag_q  <= rem_mag_d;
            qpark_q    <= qpark_d;
            qneg_cap_q <= qneg_cap_d;
            rneg_cap_q <= rneg_cap_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            quot_bcd_q <= quot_bcd_d;
            rem_bcd_q  <= rem_bcd_d;
        end
    end

    assign bus.busy_o     = busy_q;
    assign bus.valid_o    = valid_q;
    assign bus.quot_neg_o = quot_neg_q;
    assign bus.rem_neg_o  = rem_neg_q;
    assign bus.quot_bcd_o = quot_bcd_q;
    assign bus.rem_bcd_o  = rem_bcd_q;
endmodule

// File: tb/tb_div_result_bcd.sv
// Bench for div_result_bcd: table of known vectors plus random vectors
// checked against a decimal model, and hand-written handshake/reset sequences.
module tb_div_result_bcd;
    typedef struct {
        logic [7:0]  q;
        logic [7:0]  r;
        logic        s;
        logic        qn;
        logic [11:0] qb;
        logic        rn;
        logic [11:0] rb;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   busy_rises = 0;
    logic busy_prev = 1'b0;
    vec_t sb_q[$];

    div_result_bcd_if #(.W(8), .DIGITS(3)) bus ();

    div_result_bcd #(.INPUT_BIT_WIDTH(8), .DIGITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        busy_prev <= bus.busy_o;
        if (bus.busy_o && !busy_prev) busy_rises <= busy_rises + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input logic [7:0] v);
        int m;
        m = int'(v);
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic vec_t model(input logic [7:0] q, input logic [7:0] r, input logic s);
        vec_t e;
        logic [7:0] qm, rm;
        e.q = q; e.r = r; e.s = s;
        e.qn = s && (q >= 8'd128);
        e.rn = s && (r >= 8'd128);
        qm = e.qn ? 8'(256 - int'(q)) : q;
        rm = e.rn ? 8'(256 - int'(r)) : r;
        e.qb = to_bcd(qm);
        e.rb = to_bcd(rm);
        return e;
    endfunction

    task automatic drive_start(input vec_t v, input bit push);
        @(negedge clk);
        bus.in_ready_i = 1'b0;
        @(negedge clk);
        bus.quotient_i  = v.q;
        bus.remainder_i = v.r;
        bus.sign_i      = v.s;
        bus.in_ready_i  = 1'b1;
        if (push) sb_q.push_back(v);
    endtask

    task automatic wait_result(input bit toggle);
        vec_t e;
        int   lat;
        bit   got;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 40) begin
            lat++;
            @(posedge clk);
            #1;
            if (lat == 1) check("busy_after_start", 32'(bus.busy_o), 32'd1);
            if (bus.valid_o) got = 1'b1;
            else if (toggle && lat >= 4 && lat <= 13) bus.in_ready_i = lat[0];
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL valid_timeout: actual no valid after %0d cycles required 17", lat);
        end else begin
            check("latency", 32'(lat), 32'd17);
            check("busy_at_done", 32'(bus.busy_o), 32'd0);
        end
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty: actual 0 entries required 1");
        end else begin
            e = sb_q.pop_front();
            check("quot_neg", 32'(bus.quot_neg_o), 32'(e.qn));
            check("quot_bcd", 32'(bus.quot_bcd_o), 32'(e.qb));
            check("rem_neg",  32'(bus.rem_neg_o),  32'(e.rn));
            check("rem_bcd",  32'(bus.rem_bcd_o),  32'(e.rb));
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        bus.ack_i = 1'b1;
        @(posedge clk);
        #1;
        check("ack_clears_valid", 32'(bus.valid_o), 32'd0);
        @(negedge clk);
        bus.ack_i = 1'b0;
    endtask

    task automatic run_one(input vec_t v);
        drive_start(v, 1'b1);
        wait_result(1'b0);
        do_ack();
    endtask

    initial begin
        vec_t tbl[8];
        vec_t v;
        int   rises0;
        bit   stable;

        tbl[0] = '{8'd6,   8'd1,   1'b0, 1'b0, 12'h006, 1'b0, 12'h001};
        tbl[1] = '{8'hF9,  8'hFF,  1'b1, 1'b1, 12'h007, 1'b1, 12'h001};
        tbl[2] = '{8'd255, 8'd0,   1'b0, 1'b0, 12'h255, 1'b0, 12'h000};
        tbl[3] = '{8'h80,  8'h00,  1'b1, 1'b1, 12'h128, 1'b0, 12'h000};
        tbl[4] = '{8'h7F,  8'h05,  1'b1, 1'b0, 12'h127, 1'b0, 12'h005};
        tbl[5] = '{8'hF9,  8'hFF,  1'b0, 1'b0, 12'h249, 1'b0, 12'h255};
        tbl[6] = '{8'h80,  8'h81,  1'b1, 1'b1, 12'h128, 1'b1, 12'h127};
        tbl[7] = '{8'h00,  8'h00,  1'b1, 1'b0, 12'h000, 1'b0, 12'h000};

        rst_n           = 1'b0;
        bus.in_ready_i  = 1'b1;
        bus.quotient_i  = 8'd12;
        bus.remainder_i = 8'd3;
        bus.sign_i      = 1'b0;
        bus.ack_i       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(bus.busy_o),  32'd0);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_neg",   32'({bus.quot_neg_o, bus.rem_neg_o}), 32'd0);
        check("rst_bcd",   32'({bus.quot_bcd_o, bus.rem_bcd_o}), 32'd0);

        // Ready already high at reset release must not start a conversion.
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("no_start_at_release", 32'(busy_rises), 32'd0);
        check("no_valid_at_release", 32'(bus.valid_o), 32'd0);

        for (int i = 0; i < 8; i++) run_one(tbl[i]);

        for (int i = 0; i < 6; i++) begin
            v = model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            run_one(v);
        end

        // Ready held high plus extra pulses during Busy: exactly one result.
        rises0 = busy_rises;
        drive_start('{8'd3, 8'd2, 1'b0, 1'b0, 12'h003, 1'b0, 12'h002}, 1'b1);
        wait_result(1'b1);
        do_ack();
        repeat (30) @(negedge clk);
        check("single_result", 32'(busy_rises - rises0), 32'd1);

        // Ack withheld: data and Valid stay put.
        drive_start('{8'd42, 8'd9, 1'b0, 1'b0, 12'h042, 1'b0, 12'h009}, 1'b1);
        wait_result(1'b0);
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 10) bus.in_ready_i = 1'b0;
            if (bus.valid_o !== 1'b1 || bus.quot_bcd_o !== 12'h042 || bus.rem_bcd_o !== 12'h009)
                stable = 1'b0;
        end
        check("hold_stable", 32'(stable), 32'd1);

        // Start and Ack in the same DONE cycle: back to IDLE, Start dropped.
        rises0 = busy_rises;
        bus.quotient_i = 8'd77;
        bus.in_ready_i = 1'b1;
        bus.ack_i      = 1'b1;
        @(posedge clk);
        #1;
        check("start_ack_valid", 32'(bus.valid_o), 32'd0);
        @(negedge clk);
        bus.ack_i = 1'b0;
        repeat (25) @(negedge clk);
        check("start_ack_lost", 32'(busy_rises - rises0), 32'd0);
        check("outputs_kept", 32'(bus.quot_bcd_o), 32'h042);

        // Reset in the middle of the remainder phase.
        drive_start('{8'd99, 8'd77, 1'b0, 1'b0, 12'h099, 1'b0, 12'h077}, 1'b0);
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy",  32'(bus.busy_o),  32'd0);
        check("abort_valid", 32'(bus.valid_o), 32'd0);
        check("abort_bcd",   32'({bus.quot_bcd_o, bus.rem_bcd_o}), 32'd0);
        check("abort_neg",   32'({bus.quot_neg_o, bus.rem_neg_o}), 32'd0);
        @(negedge clk);
        bus.in_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_one('{8'h9C, 8'h0B, 1'b1, 1'b1, 12'h100, 1'b0, 12'h011});

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
